// File: rtl/common_pseudo_lru_set_array_if.sv
// Request/response bundle for the multi-set tree PLRU victim picker.
// master drives touches and queries; slave returns the registered pick.
interface common_pseudo_lru_set_array_if #(
  parameter int WAYS_LOG2 = 3,
  parameter int SETS_LOG2 = 6
);
  localparam int N  = 1 << WAYS_LOG2;
  localparam int SW = (SETS_LOG2 > 0) ? SETS_LOG2 : 1;

  logic                 flush;
  logic                 t_en;
  logic [SW-1:0]        t_set;
  logic [N-1:0]         t_way;
  logic                 q_en;
  logic [SW-1:0]        q_set;
  logic [N-1:0]         q_dvalid;
  logic [N-1:0]         q_lock;
  logic                 r_valid;
  logic [N-1:0]         r_way_onehot;
  logic [WAYS_LOG2-1:0] r_way_bin;
  logic                 r_none;

  modport master (
    output flush, t_en, t_set, t_way,
    output q_en, q_set, q_dvalid, q_lock,
    input  r_valid, r_way_onehot, r_way_bin, r_none
  );

  modport slave (
    input  flush, t_en, t_set, t_way,
    input  q_en, q_set, q_dvalid, q_lock,
    output r_valid, r_way_onehot, r_way_bin, r_none
  );
endinterface

// File: rtl/common_pseudo_lru_set_array.sv
// Multi-set tree pseudo-LRU victim picker with touch bypass,
// eligibility/lock masking and optional auto-touch of the pick.
module common_pseudo_lru_set_array #(
  parameter int WAYS_LOG2       = 3,
  parameter int SETS_LOG2       = 6,
  parameter bit PICK_AUTO_TOUCH = 1'b0
) (
  input logic clk,
  input logic reset,
  common_pseudo_lru_set_array_if.slave bus
);
  localparam int W     = WAYS_LOG2;
  localparam int N     = 1 << W;
  localparam int NODES = N - 1;
  localparam int SETS  = 1 << SETS_LOG2;

  typedef logic [NODES-1:0] tree_t;

  tree_t          tree_q [SETS];
  tree_t          tree_d [SETS];
  logic           r_valid_q;
  logic           r_none_q;
  logic [N-1:0]   r_onehot_q;
  logic [W-1:0]   r_bin_q;

  logic [N-1:0]   elig;
  logic [2*N-2:0] sub;
  tree_t          cur;
  logic [W-1:0]   t_idx;
  logic [W-1:0]   pick;
  logic           t_hit;
  logic           none;
  logic           lo, hi, nb, go;
  int             ts, qs, node;

  // Point every node on the root->way path away from that way.
  function automatic tree_t touch(tree_t tr, logic [W-1:0] way);
    tree_t r;
    int    n;
    r = tr;
    n = 0;
    for (int l = 0; l < W; l++) begin
      for (int k = 0; k < NODES; k++)
        if (k == n) r[k] = ~way[W-1-l];
      n = 2*n + 1 + int'(way[W-1-l]);
    end
    return r;
  endfunction

  always_comb begin
    ts = 0;
    qs = 0;
    if (SETS_LOG2 > 0) begin
      ts = int'(bus.t_set);
      qs = int'(bus.q_set);
    end
    t_hit = |bus.t_way;
    t_idx = '0;
    for (int i = N-1; i >= 0; i--)
      if (bus.t_way[i]) t_idx = W'(i);

    // Queried set as it will look after this cycle's touch/flush.
    cur = '0;
    for (int s = 0; s < SETS; s++)
      if (s == qs) cur = tree_q[s];
    if (bus.t_en && t_hit && ts == qs) cur = touch(cur, t_idx);
    if (bus.flush) cur = '0;

    elig = bus.q_dvalid & ~bus.q_lock;
    sub  = '0;
    for (int i = 0; i < N; i++) sub[NODES+i] = elig[i];
    for (int k = NODES-1; k >= 0; k--)
      sub[k] = sub[2*k+1] | sub[2*k+2];

    pick = '0;
    node = 0;
    for (int l = 0; l < W; l++) begin
      lo = 1'b0;
      hi = 1'b0;
      nb = 1'b0;
      for (int k = 0; k < NODES; k++)
        if (k == node) begin
          lo = sub[2*k+1];
          hi = sub[2*k+2];
          nb = cur[k];
        end
      go = (lo && hi) ? nb : hi;
      pick[W-1-l] = go;
      node = 2*node + 1 + int'(go);
    end
    none = ~sub[0];

    // External touch first, then auto-touch; flush overrides both.
    for (int s = 0; s < SETS; s++) begin
      tree_d[s] = tree_q[s];
      if (bus.t_en && t_hit && s == ts)
        tree_d[s] = touch(tree_d[s], t_idx);
      if (PICK_AUTO_TOUCH && bus.q_en && !none && s == qs)
        tree_d[s] = touch(tree_d[s], pick);
      if (bus.flush) tree_d[s] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
      r_valid_q  <= 1'b0;
      r_none_q   <= 1'b0;
      r_onehot_q <= '0;
      r_bin_q    <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= tree_d[s];
      r_valid_q <= bus.q_en;
      if (bus.q_en) begin
        r_none_q   <= none;
        r_bin_q    <= none ? '0 : pick;
        r_onehot_q <= none ? '0 : (N'(1) << pick);
      end
    end
  end

  assign bus.r_valid      = r_valid_q;
  assign bus.r_none       = r_none_q;
  assign bus.r_way_onehot = r_onehot_q;
  assign bus.r_way_bin    = r_bin_q;
endmodule

// File: tb/tb_common_pseudo_lru_set_array.sv
// Bench for the PLRU set array: 4 ways x 4 sets, one plain and one
// auto-touch instance, checked against a range-walking model.
module tb_common_pseudo_lru_set_array;
  typedef bit [2:0] tr_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  common_pseudo_lru_set_array_if #(.WAYS_LOG2(2), .SETS_LOG2(2)) i0 ();
  common_pseudo_lru_set_array_if #(.WAYS_LOG2(2), .SETS_LOG2(2)) i1 ();

  common_pseudo_lru_set_array #(
    .WAYS_LOG2(2), .SETS_LOG2(2), .PICK_AUTO_TOUCH(1'b0)
  ) dut0 (.clk(clk), .reset(reset), .bus(i0));

  common_pseudo_lru_set_array #(
    .WAYS_LOG2(2), .SETS_LOG2(2), .PICK_AUTO_TOUCH(1'b1)
  ) dut1 (.clk(clk), .reset(reset), .bus(i1));

  always #5 clk = ~clk;

  tr_t      mt [2][4];
  bit       ev [2];
  bit [3:0] eo [2];
  bit [1:0] eb [2];
  bit       en [2];

  function automatic tr_t m_touch(tr_t t, int w);
    int node, lo, size, half;
    node = 0; lo = 0; size = 4;
    while (size > 1) begin
      half = size / 2;
      if (w < lo + half) begin
        t[node] = 1'b1;
        node = 2*node + 1;
      end else begin
        t[node] = 1'b0;
        node = 2*node + 2;
        lo += half;
      end
      size = half;
    end
    return t;
  endfunction

  function automatic int m_pick(tr_t t, bit [3:0] e);
    int node, lo, size, half;
    bit lok, hok, up;
    if (e == 4'b0) return -1;
    node = 0; lo = 0; size = 4;
    while (size > 1) begin
      half = size / 2;
      lok = 1'b0;
      hok = 1'b0;
      for (int i = 0; i < half; i++) begin
        lok |= e[lo+i];
        hok |= e[lo+half+i];
      end
      up = (lok && hok) ? t[node] : hok;
      if (up) begin
        lo += half;
        node = 2*node + 2;
      end else node = 2*node + 1;
      size = half;
    end
    return lo;
  endfunction

  function automatic int lowest(bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic m_step(input int d, input bit at, input bit fl,
                        input bit te, input bit [1:0] ts,
                        input bit [3:0] tw, input bit qe,
                        input bit [1:0] qs, input bit [3:0] dv,
                        input bit [3:0] lk);
    tr_t cur;
    int  twi, p;
    twi = te ? lowest(tw) : -1;
    cur = mt[d][qs];
    if (twi >= 0 && ts == qs) cur = m_touch(cur, twi);
    if (fl) cur = '0;
    p = m_pick(cur, dv & ~lk);
    ev[d] = qe;
    if (qe) begin
      en[d] = (p < 0);
      eb[d] = (p < 0) ? 2'd0 : 2'(p);
      eo[d] = (p < 0) ? 4'd0 : (4'b0001 << p);
    end
    if (fl) begin
      for (int s = 0; s < 4; s++) mt[d][s] = '0;
    end else begin
      if (twi >= 0) mt[d][ts] = m_touch(mt[d][ts], twi);
      if (at && qe && p >= 0) mt[d][qs] = m_touch(mt[d][qs], p);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 4; s++) mt[d][s] = '0;
        ev[d] = 1'b0; eo[d] = '0; eb[d] = '0; en[d] = 1'b0;
      end
    end else begin
      m_step(0, 1'b0, i0.flush, i0.t_en, i0.t_set, i0.t_way,
             i0.q_en, i0.q_set, i0.q_dvalid, i0.q_lock);
      m_step(1, 1'b1, i1.flush, i1.t_en, i1.t_set, i1.t_way,
             i1.q_en, i1.q_set, i1.q_dvalid, i1.q_lock);
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (valid,onehot,bin,none)",
               nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cycle_dut0",
        {i0.r_valid, i0.r_way_onehot, i0.r_way_bin, i0.r_none},
        {ev[0], eo[0], eb[0], en[0]});
    chk("cycle_dut1",
        {i1.r_valid, i1.r_way_onehot, i1.r_way_bin, i1.r_none},
        {ev[1], eo[1], eb[1], en[1]});
  end

  task automatic drv(input int d, input bit fl, input bit te,
                     input bit [1:0] ts, input bit [3:0] tw,
                     input bit qe, input bit [1:0] qs,
                     input bit [3:0] dv, input bit [3:0] lk);
    if (d == 0) begin
      i0.flush = fl; i0.t_en = te; i0.t_set = ts; i0.t_way = tw;
      i0.q_en = qe; i0.q_set = qs; i0.q_dvalid = dv; i0.q_lock = lk;
    end else begin
      i1.flush = fl; i1.t_en = te; i1.t_set = ts; i1.t_way = tw;
      i1.q_en = qe; i1.q_set = qs; i1.q_dvalid = dv; i1.q_lock = lk;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int d, input bit v,
                     input bit [3:0] oh, input bit [1:0] b,
                     input bit n);
    if (d == 0)
      chk(nm, {i0.r_valid, i0.r_way_onehot, i0.r_way_bin, i0.r_none},
          {v, oh, b, n});
    else
      chk(nm, {i1.r_valid, i1.r_way_onehot, i1.r_way_bin, i1.r_none},
          {v, oh, b, n});
  endtask

  task automatic query(input int d, input bit [1:0] s);
    drv(d, 0, 0, 0, 0, 1, s, 4'hF, 4'h0);
  endtask

  task automatic touch(input int d, input bit [1:0] s,
                       input bit [3:0] w);
    drv(d, 0, 1, s, w, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    query(0, 2'd1); tick(); lit("reset_pick", 0, 1, 4'b0001, 0, 0);

    touch(0, 2'd1, 4'b0001); tick();
    query(0, 2'd1); tick(); lit("after_t0", 0, 1, 4'b0100, 2, 0);
    touch(0, 2'd1, 4'b0100); tick();
    query(0, 2'd1); tick(); lit("after_t2", 0, 1, 4'b0010, 1, 0);
    query(0, 2'd0); tick(); lit("isolation", 0, 1, 4'b0001, 0, 0);

    drv(0, 0, 0, 0, 0, 1, 2'd3, 4'hF, 4'b0011); tick();
    lit("lock_low", 0, 1, 4'b0100, 2, 0);
    drv(0, 0, 0, 0, 0, 1, 2'd3, 4'b0100, 4'b0100); tick();
    lit("none", 0, 1, 4'b0000, 0, 1);

    touch(0, 2'd3, 4'b0000); tick();
    query(0, 2'd3); tick(); lit("zero_touch", 0, 1, 4'b0001, 0, 0);
    touch(0, 2'd3, 4'b1010); tick();
    query(0, 2'd3); tick(); lit("multihot_a", 0, 1, 4'b0100, 2, 0);
    drv(0, 0, 0, 0, 0, 1, 2'd3, 4'b0011, 4'b0000); tick();
    lit("multihot_b", 0, 1, 4'b0001, 0, 0);

    drv(0, 0, 1, 2'd2, 4'b0001, 1, 2'd2, 4'hF, 4'h0); tick();
    lit("bypass", 0, 1, 4'b0100, 2, 0);
    drv(0, 1, 1, 2'd2, 4'b0001, 1, 2'd2, 4'hF, 4'h0); tick();
    lit("flush_bypass", 0, 1, 4'b0001, 0, 0);
    query(0, 2'd2); tick(); lit("post_flush_s2", 0, 1, 4'b0001, 0, 0);
    query(0, 2'd1); tick(); lit("post_flush_s1", 0, 1, 4'b0001, 0, 0);

    drv(0, 0, 1, 2'd0, 4'b0001, 1, 2'd1, 4'hF, 4'h0); tick();
    lit("other_set", 0, 1, 4'b0001, 0, 0);
    query(0, 2'd0); tick(); lit("other_set_b", 0, 1, 4'b0100, 2, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

    query(1, 2'd0);
    tick(); lit("auto_1", 1, 1, 4'b0001, 0, 0);
    tick(); lit("auto_2", 1, 1, 4'b0100, 2, 0);
    tick(); lit("auto_3", 1, 1, 4'b0010, 1, 0);
    tick(); lit("auto_4", 1, 1, 4'b1000, 3, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);

    query(0, 2'd0); tick(); lit("pre_reset", 0, 1, 4'b0100, 2, 0);
    reset = 1'b1;
    #1 lit("async_reset", 0, 0, 4'b0000, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    query(0, 2'd0); tick(); lit("after_reset", 0, 1, 4'b0001, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
